cp0_unit: RTL and testbench
===========================

# cp0_unit

Coprocessor-0 unit for the MIPS 5-stage pipeline. It sits beside the EXE stage and takes the `oper` code and register addresses that the pipeline controller decodes from `MTC0`, `MFC0` and `ERET`. It holds the status, cause, EPC and handler-base registers and latches external interrupt requests. It drives `jump_en`/`jump_addr` back to the controller and PC mux, which flushes ID and redirects fetch.

## Interface
- No parameters.
- `clk` in 1: main clock.
- `rst` in 1: reset, synchronous, active-high; clock `clk`.
- `en` in 1: stage enable (EXE enable). When low: no register update, no interrupt take.
- `oper` in 2: `0` = NONE, `1` = STORE (MTC0), `2` = ERET, `3` = reserved (treated as NONE).
- `addr_r` in 5: CP0 read address (MFC0 `rd`).
- `data_r` out 32: combinational read data.
- `addr_w` in 5: CP0 write address (MTC0 `rd`).
- `data_w` in 32: MTC0 write data (forwarded `rt`).
- `ret_addr` in 32: PC of the instruction to resume at, saved to EPC on interrupt.
- `ir_in` in 1: external interrupt request, level.
- `jump_en` out 1: redirect fetch this cycle.
- `jump_addr` out 32: redirect target.

## Operation
- Implemented registers:
  - SR = 12: bit0 IE, bit1 EXL. Other bits are written and read back.
  - CAUSE = 13: bit10 IP, read-only mirror of `pending`. Other bits read 0.
  - EPC = 14.
  - EHBR = 25: handler base.
- Unimplemented addresses read 0, and writes to them are ignored. CAUSE is not writable.
- Read: `data_r` = register[`addr_r`], combinational. Same-cycle MTC0 to the same address is not bypassed.
- Edge detect: `ir_s` is the (optionally synchronized) request and `ir_d` is its 1-cycle delay. `ir_s & ~ir_d` sets `pending`. `pending` keeps latching while `en` is low.
- `take_irq` = `en & pending & SR.IE & ~SR.EXL & oper!=ERET & ~rst`.
- `do_eret` = `en & oper==ERET & ~rst`.
- Outputs:
  - `jump_en` = `take_irq | do_eret`.
  - `jump_addr` = EPC if `do_eret`, else EHBR.
- At the clock edge after `take_irq`: EPC ← `ret_addr`, SR.EXL ← 1, `pending` ← 0 (unless a new edge arrives in the same cycle, which re-sets it).
- At the clock edge after `do_eret`: SR.EXL ← 0.
- MTC0 (`en & oper==STORE`): register[`addr_w`] ← `data_w` at the edge.
- Priorities when events coincide:
  - ERET vs. pending interrupt: ERET wins. The interrupt is taken at the earliest in the next cycle, once EXL is cleared.
  - MTC0 to EPC vs. `take_irq`: the interrupt save wins.
  - MTC0 to SR vs. `take_irq`: the MTC0 value is written, then EXL is forced to 1.
- A pending interrupt that is masked (IE = 0 or EXL = 1) stays pending indefinitely. It is taken on the cycle the mask clears.

## Timing
- Reset values: SR, CAUSE, EPC, EHBR, `pending`, `ir_d` and the synchronizer flops are all 0. `jump_en` = 0 while `rst` is high. `data_r` reflects the reset registers.
- `jump_en` is combinational, valid in the same cycle as the decoding instruction in EXE, and lasts exactly one cycle per event.
- MTC0 write is visible on `data_r` the cycle after the write edge.
- Interrupt latency, with `ir_in` first high at edge E0:
  - Without sync: `pending` = 1 after E0, and `jump_en` can assert in the following cycle.
  - With sync: `pending` = 1 after E2.
- A request held high gives one interrupt only. A new rising edge is required for the next one.
- `rst` asserted mid-service clears EXL and `pending`. A request edge seen in the reset cycle is discarded.

## Configuration
- `CP0_IRQ_SYNC_EN`:
  - Defined: `ir_in` passes through a two-flop synchronizer before edge detect, adding +2 cycles of latency. Use this for asynchronous board inputs.
  - Undefined: `ir_in` is treated as synchronous to `clk` and feeds edge detect directly.

## Test plan
- **Reset:** assert `rst` 2 cycles with `ir_in` = 1 and `oper` = 2 → `jump_en` = 0 throughout. Then read addresses 12/13/14/25 → all 0x00000000.
- **MTC0/MFC0:** `oper` = 1, `addr_w` = 25, `data_w` = 0x00000180; next cycle `addr_r` = 25 → `data_r` = 0x00000180. Write to address 13 → it still reads 0.
- **Interrupt take:** SR ← 0x1, `ret_addr` = 0x00000040, pulse `ir_in`.
  - `jump_en` = 1 for one cycle with `jump_addr` = 0x00000180.
  - Afterwards EPC = 0x40, SR = 0x3, CAUSE = 0.
- **Masking:** SR = 0 and pulse `ir_in` → no `jump_en`, CAUSE = 0x400. Then MTC0 SR ← 0x1 → `jump_en` asserts the cycle after the write.
- **ERET priority:** EXL = 1, a new edge pending, `oper` = 2.
  - `jump_en` = 1 with `jump_addr` = EPC, and EXL clears.
  - Next cycle the interrupt is taken, targeting 0x180.
- **Stall:** `en` = 0 while pending and enabled → `jump_en` = 0 and registers unchanged. Raise `en` → the interrupt is taken that cycle.

Source files
------------

// File: rtl/cp0_unit.sv
// cp0_unit -- Coprocessor-0 for the MIPS 5-stage pipeline.
//
// Holds SR (12), CAUSE (13, read-only), EPC (14) and the handler base EHBR (25).
// It latches rising edges of the external interrupt request and redirects
// fetch on an interrupt take or on ERET.
//
// Optional build macro: CP0_IRQ_SYNC_EN
//   When defined, ir_in goes through a two-flop synchronizer before edge
//   detection, which adds two cycles of latency.
//   When undefined, ir_in is assumed to be synchronous to clk.
//
// Ports:
//   clk, rst    clock; synchronous active-high reset
//   en          EXE stage enable. When low, no register update and no take.
//   oper        0 none, 1 MTC0 store, 2 ERET, 3 reserved (treated as none)
//   addr_r      MFC0 read address
//   data_r      combinational read data
//   addr_w      MTC0 write address
//   data_w      MTC0 write data
//   ret_addr    resume PC, saved to EPC when an interrupt is taken
//   ir_in       external interrupt request (level)
//   jump_en     redirect fetch this cycle
//   jump_addr   redirect target
module cp0_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  oper,
  input  logic [4:0]  addr_r,
  output logic [31:0] data_r,
  input  logic [4:0]  addr_w,
  input  logic [31:0] data_w,
  input  logic [31:0] ret_addr,
  input  logic        ir_in,
  output logic        jump_en,
  output logic [31:0] jump_addr
);

  localparam logic [1:0] OPER_STORE = 2'd1;
  localparam logic [1:0] OPER_ERET  = 2'd2;

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_EHBR  = 5'd25;

  logic [31:0] sr_q, sr_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] ehbr_q, ehbr_d;
  logic        pending_q, pending_d;
  logic        ir_d_q;
  logic        ir_s;
  logic        ir_edge;
  logic        is_store;
  logic        do_eret;
  logic        take_irq;

`ifdef CP0_IRQ_SYNC_EN
  logic sync1_q, sync2_q;

  // Two-flop synchronizer for an asynchronous board-level request.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= ir_in;
      sync2_q <= sync1_q;
    end
  end

  assign ir_s = sync2_q;
`else
  assign ir_s = ir_in;
`endif

  // The edge detector runs even while the stage is stalled, so that
  // requests are never lost while en is low.
  always_ff @(posedge clk) begin
    if (rst) ir_d_q <= 1'b0;
    else     ir_d_q <= ir_s;
  end

  assign ir_edge  = ir_s & ~ir_d_q;
  assign is_store = en & (oper == OPER_STORE);
  assign do_eret  = en & (oper == OPER_ERET) & ~rst;
  // ERET takes priority over a pending interrupt. The interrupt waits
  // until EXL has been cleared.
  assign take_irq = en & pending_q & sr_q[0] & ~sr_q[1] & (oper != OPER_ERET) & ~rst;

  assign jump_en   = take_irq | do_eret;
  assign jump_addr = do_eret ? epc_q : ehbr_q;

  // Next-state logic. For SR, an MTC0 is applied first and the EXL
  // update is layered on top. For EPC, the interrupt save overrides an MTC0.
  // A new request edge re-arms pending even in the cycle it is consumed.
  always_comb begin
    sr_d      = sr_q;
    epc_d     = epc_q;
    ehbr_d    = ehbr_q;
    pending_d = pending_q;
    if (is_store) begin
      case (addr_w)
        ADDR_SR:   sr_d   = data_w;
        ADDR_EPC:  epc_d  = data_w;
        ADDR_EHBR: ehbr_d = data_w;
        default:   ;
      endcase
    end
    if (do_eret) sr_d[1] = 1'b0;
    if (take_irq) begin
      sr_d[1]   = 1'b1;
      epc_d     = ret_addr;
      pending_d = 1'b0;
    end
    if (ir_edge) pending_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q      <= '0;
      epc_q     <= '0;
      ehbr_q    <= '0;
      pending_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      if (en) begin
        sr_q   <= sr_d;
        epc_q  <= epc_d;
        ehbr_q <= ehbr_d;
      end
    end
  end

  // MFC0 read port. CAUSE only exposes the pending bit, at IP (bit 10).
  always_comb begin
    data_r = '0;
    case (addr_r)
      ADDR_SR:    data_r = sr_q;
      ADDR_CAUSE: data_r = {21'd0, pending_q, 10'd0};
      ADDR_EPC:   data_r = epc_q;
      ADDR_EHBR:  data_r = ehbr_q;
      default:    data_r = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_unit.sv
// tb_cp0_unit -- directed test-plan steps followed by randomized traffic.
// All outputs are compared against a register-level behavioural model of
// CP0 that is kept inside this bench.
module tb_cp0_unit;

`ifdef CP0_IRQ_SYNC_EN
  localparam int IRQ_LAT = 2;
`else
  localparam int IRQ_LAT = 0;
`endif

  logic        clk;
  logic        rst;
  logic        en;
  logic [1:0]  oper;
  logic [4:0]  addr_r;
  logic [31:0] data_r;
  logic [4:0]  addr_w;
  logic [31:0] data_w;
  logic [31:0] ret_addr;
  logic        ir_in;
  logic        jump_en;
  logic [31:0] jump_addr;

  int vecCount = 0;
  int missCount = 0;

  // Architectural model state.
  logic [31:0] mSr, mEpc, mEhbr;
  logic        mPend;
  // irHist[k] holds the value of ir_in k cycles ago; irHist[0] is the current value.
  logic        irHist [0:3];

  cp0_unit dut (
    .clk(clk), .rst(rst), .en(en), .oper(oper),
    .addr_r(addr_r), .data_r(data_r),
    .addr_w(addr_w), .data_w(data_w),
    .ret_addr(ret_addr), .ir_in(ir_in),
    .jump_en(jump_en), .jump_addr(jump_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] modelRead(input logic [4:0] a);
    case (a)
      5'd12:   return mSr;
      5'd13:   return mPend ? 32'h0000_0400 : 32'h0;
      5'd14:   return mEpc;
      5'd25:   return mEhbr;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic modelTake();
    return !rst && en && mPend && mSr[0] && !mSr[1] && oper != 2'd2;
  endfunction

  function automatic logic modelEret();
    return !rst && en && oper == 2'd2;
  endfunction

  // Drive inputs, then wait until mid-cycle, away from the clock edge.
  task automatic applyStimulus(input logic enV, input logic [1:0] opV, input logic [4:0] ar,
                               input logic [4:0] aw, input logic [31:0] dw,
                               input logic [31:0] ra, input logic irV, input logic rsV);
    en = enV; oper = opV; addr_r = ar; addr_w = aw; data_w = dw;
    ret_addr = ra; ir_in = irV; rst = rsV;
    irHist[0] = irV;
    #4;
  endtask

  task automatic checkOutput();
    logic        expJump;
    logic [31:0] expAddr;
    logic [31:0] expData;
    expJump = modelTake() | modelEret();
    expAddr = modelEret() ? mEpc : mEhbr;
    expData = modelRead(addr_r);
    vecCount++;
    assert (jump_en === expJump) else begin
      missCount++;
      $error("[TB] FAIL jump_en got %0b want %0b (t=%0t)", jump_en, expJump, $time);
    end
    vecCount++;
    assert (jump_addr === expAddr) else begin
      missCount++;
      $error("[TB] FAIL jump_addr got %h want %h (t=%0t)", jump_addr, expAddr, $time);
    end
    vecCount++;
    assert (data_r === expData) else begin
      missCount++;
      $error("[TB] FAIL data_r[%0d] got %h want %h (t=%0t)", addr_r, data_r, expData, $time);
    end
  endtask

  task automatic checkConst(input string tag, input logic [31:0] got, input logic [31:0] want);
    vecCount++;
    assert (got === want) else begin
      missCount++;
      $error("[TB] FAIL %s got %h want %h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Apply the clock edge to the model, then step the DUT.
  task automatic advance();
    logic take, eret, edgeSeen;
    if (rst) begin
      mSr = 0; mEpc = 0; mEhbr = 0; mPend = 0;
      irHist[1] = 0; irHist[2] = 0; irHist[3] = 0;
    end else begin
      take = modelTake();
      eret = modelEret();
      edgeSeen = irHist[IRQ_LAT] && !irHist[IRQ_LAT+1];
      if (en && oper == 2'd1) begin
        if (addr_w == 5'd12) mSr = data_w;
        if (addr_w == 5'd14) mEpc = data_w;
        if (addr_w == 5'd25) mEhbr = data_w;
      end
      if (eret) mSr[1] = 1'b0;
      if (take) begin
        mSr[1] = 1'b1;
        mEpc = ret_addr;
        mPend = 1'b0;
      end
      if (edgeSeen) mPend = 1'b1;
      irHist[3] = irHist[2]; irHist[2] = irHist[1]; irHist[1] = irHist[0];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pre(input logic enV, input logic [1:0] opV, input logic [4:0] ar,
                     input logic [4:0] aw, input logic [31:0] dw,
                     input logic [31:0] ra, input logic irV, input logic rsV);
    applyStimulus(enV, opV, ar, aw, dw, ra, irV, rsV);
    checkOutput();
  endtask

  task automatic run(input logic enV, input logic [1:0] opV, input logic [4:0] ar,
                     input logic [4:0] aw, input logic [31:0] dw,
                     input logic [31:0] ra, input logic irV, input logic rsV);
    pre(enV, opV, ar, aw, dw, ra, irV, rsV);
    advance();
  endtask

  // Directed test-plan steps, followed by a randomized run.
  initial begin
    logic [4:0]  rdAddrs [4];
    logic [4:0]  pick [5];
    logic        irV;
    logic [4:0]  ar, aw;
    rdAddrs = '{5'd12, 5'd13, 5'd14, 5'd25};

    mSr = 0; mEpc = 0; mEhbr = 0; mPend = 0;
    for (int i = 0; i < 4; i++) irHist[i] = 1'b0;

    // Unchecked initial reset to bring the DUT flops out of X.
    rst = 1; en = 0; oper = 0; addr_r = 0; addr_w = 0; data_w = 0; ret_addr = 0; ir_in = 0;
    @(posedge clk); #1;

    // Reset held for two cycles with a request and ERET present.
    repeat (2) begin
      pre(1, 2, 5'd12, 0, 0, 0, 1, 1);
      checkConst("rst_jump_en", 32'(jump_en), 32'h0);
      advance();
    end
    foreach (rdAddrs[i]) begin
      pre(1, 0, rdAddrs[i], 0, 0, 0, 0, 0);
      checkConst("rst_read", data_r, 32'h0);
      advance();
    end

    // MTC0/MFC0 round trip; CAUSE is not writable.
    run(1, 1, 5'd25, 5'd25, 32'h180, 0, 0, 0);
    pre(1, 0, 5'd25, 0, 0, 0, 0, 0);
    checkConst("mfc0_ehbr", data_r, 32'h180);
    advance();
    run(1, 1, 5'd13, 5'd13, 32'hFFFF_FFFF, 0, 0, 0);
    pre(1, 0, 5'd13, 0, 0, 0, 0, 0);
    checkConst("cause_ro", data_r, 32'h0);
    advance();

    // Interrupt take.
    run(1, 1, 5'd12, 5'd12, 32'h1, 32'h40, 0, 0);
    run(1, 0, 5'd12, 0, 0, 32'h40, 1, 0);
    repeat (IRQ_LAT) run(1, 0, 5'd12, 0, 0, 32'h40, 0, 0);
    pre(1, 0, 5'd12, 0, 0, 32'h40, 0, 0);
    checkConst("take_jump_en", 32'(jump_en), 32'h1);
    checkConst("take_jump_addr", jump_addr, 32'h180);
    advance();
    pre(1, 0, 5'd14, 0, 0, 32'h40, 0, 0);
    checkConst("take_one_cycle", 32'(jump_en), 32'h0);
    checkConst("take_epc", data_r, 32'h40);
    advance();
    pre(1, 0, 5'd12, 0, 0, 0, 0, 0);
    checkConst("take_sr", data_r, 32'h3);
    advance();
    pre(1, 0, 5'd13, 0, 0, 0, 0, 0);
    checkConst("take_cause", data_r, 32'h0);
    advance();

    // Masked interrupt stays pending until the mask clears.
    run(1, 1, 5'd12, 5'd12, 32'h0, 0, 0, 0);
    run(1, 0, 5'd13, 0, 0, 0, 1, 0);
    repeat (IRQ_LAT) run(1, 0, 5'd13, 0, 0, 0, 0, 0);
    pre(1, 0, 5'd13, 0, 0, 0, 0, 0);
    checkConst("mask_no_jump", 32'(jump_en), 32'h0);
    checkConst("mask_cause", data_r, 32'h400);
    advance();
    pre(1, 1, 5'd12, 5'd12, 32'h1, 32'h40, 0, 0);
    checkConst("mask_write_cycle", 32'(jump_en), 32'h0);
    advance();
    pre(1, 0, 5'd12, 0, 0, 32'h40, 0, 0);
    checkConst("unmask_jump", 32'(jump_en), 32'h1);
    advance();

    // ERET beats a pending interrupt; the interrupt follows one cycle later.
    run(1, 0, 5'd12, 0, 0, 0, 1, 0);
    repeat (IRQ_LAT) run(1, 0, 5'd12, 0, 0, 0, 0, 0);
    pre(1, 2, 5'd14, 0, 0, 32'h99, 0, 0);
    checkConst("eret_jump_en", 32'(jump_en), 32'h1);
    checkConst("eret_jump_addr", jump_addr, 32'h40);
    advance();
    pre(1, 0, 5'd12, 0, 0, 32'h44, 0, 0);
    checkConst("post_eret_take", 32'(jump_en), 32'h1);
    checkConst("post_eret_addr", jump_addr, 32'h180);
    advance();
    pre(1, 0, 5'd14, 0, 0, 0, 0, 0);
    checkConst("post_eret_epc", data_r, 32'h44);
    advance();

    // Stall: a request latched while en is low is taken when en rises.
    run(1, 1, 5'd12, 5'd12, 32'h1, 0, 0, 0);
    run(0, 0, 5'd12, 0, 0, 32'h50, 1, 0);
    repeat (IRQ_LAT + 2) begin
      pre(0, 0, 5'd12, 5'd12, 32'h0, 32'h50, 0, 0);
      checkConst("stall_no_jump", 32'(jump_en), 32'h0);
      checkConst("stall_sr", data_r, 32'h1);
      advance();
    end
    pre(1, 0, 5'd14, 0, 0, 32'h50, 0, 0);
    checkConst("stall_release", 32'(jump_en), 32'h1);
    advance();
    pre(1, 0, 5'd14, 0, 0, 0, 0, 0);
    checkConst("stall_epc", data_r, 32'h50);
    advance();

    // Randomized traffic against the model.
    pick = '{5'd12, 5'd13, 5'd14, 5'd25, 5'd0};
    irV = 1'b0;
    for (int n = 0; n < 600; n++) begin
      pick[4] = 5'($urandom);
      ar = pick[$urandom_range(0, 4)];
      aw = pick[$urandom_range(0, 4)];
      if ($urandom_range(0, 2) == 0) irV = ~irV;
      run(($urandom_range(0, 4) != 0), 2'($urandom_range(0, 3)), ar, aw,
          ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom,
          $urandom, irV, ($urandom_range(0, 63) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
